// File: rtl/rf_alu_exec_unit.sv
// Register file with a single-issue ALU run by a four-phase IDLE/READ/EXEC/WB sequencer.
// Optional feature macro: RF_ALU_R0_ZERO_EN (R0 reads as zero and ignores all writes).
module rf_alu_exec_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALU_Op,
    input  logic             ALU_B_Sel,
    input  logic [1:0]       Imm_Sel,
    input  logic [15:0]      Instr,
    input  logic [AW-1:0]    Rm_Rd_to_RF,
    input  logic [AW-1:0]    Rn_to_RF,
    input  logic [AW-1:0]    Rd_to_RF,
    input  logic             WB_en,
    input  logic             RF_Write_en,
    input  logic [AW-1:0]    Write_Addr,
    input  logic [WIDTH-1:0] Write_Data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [WIDTH-1:0] Imm_Out,
    output logic [3:0]       NZVC,
    output logic [WIDTH-1:0] ReadA_data
);
`ifdef RF_ALU_R0_ZERO_EN
    localparam bit R0Zero = 1'b1;
`else
    localparam bit R0Zero = 1'b0;
`endif

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLsl = 3'd5;
    localparam logic [2:0] OpLsr = 3'd6;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;
    state_e state;

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] read_b;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic             wb_en_q;

    logic [WIDTH-1:0] add_b, alu_res;
    logic [WIDTH:0]   sum;
    logic             add_cin, flag_v, flag_c;
    logic [3:0]       flags;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             unused_instr;

    assign unused_instr = ^Instr[15:8];

    assign ReadA_data = (R0Zero && Rm_Rd_to_RF == '0) ? '0 : regs[Rm_Rd_to_RF];
    assign read_b     = (R0Zero && Rn_to_RF == '0) ? '0 : regs[Rn_to_RF];

    always_comb begin
        Imm_Out = '0;
        unique case (Imm_Sel)
            2'b00: Imm_Out = {{(WIDTH-5){Instr[4]}}, Instr[4:0]};
            2'b01: Imm_Out = {{(WIDTH-8){Instr[7]}}, Instr[7:0]};
            2'b10: Imm_Out = WIDTH'(Instr[7:0]);
            2'b11: Imm_Out = WIDTH'({Instr[7:0], ReadA_data[7:0]});
        endcase
    end

    // SUB shares the adder as A + ~B + 1 so carry-out means "no borrow".
    always_comb begin
        add_cin = (op_q == OpSub);
        add_b   = add_cin ? ~op_b : op_b;
        sum     = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        alu_res = '0;
        flag_v  = 1'b0;
        flag_c  = 1'b0;
        case (op_q)
            OpAdd, OpSub: begin
                alu_res = sum[WIDTH-1:0];
                flag_c  = sum[WIDTH];
                flag_v  = (op_a[WIDTH-1] == add_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OpAnd: alu_res = op_a & op_b;
            OpOr:  alu_res = op_a | op_b;
            OpXor: alu_res = op_a ^ op_b;
            OpLsl: begin
                alu_res = {op_a[WIDTH-2:0], 1'b0};
                flag_c  = op_a[WIDTH-1];
            end
            OpLsr: begin
                alu_res = {1'b0, op_a[WIDTH-1:1]};
                flag_c  = op_a[0];
            end
            default: alu_res = op_b;
        endcase
        flags = {alu_res[WIDTH-1], alu_res == '0, flag_v, flag_c};
    end

    // Single write port: external writes own it in IDLE, writeback owns it in WB.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = Write_Addr;
        wr_data = Write_Data;
        if (state == StIdle) begin
            wr_en = RF_Write_en;
        end else if (state == StWb) begin
            wr_en   = wb_en_q;
            wr_addr = rd_q;
            wr_data = ALU_Out;
        end
        if (R0Zero && wr_addr == '0) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            ALU_Out <= '0;
            NZVC    <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StRead;
                        busy  <= 1'b1;
                    end
                end
                StRead: begin
                    op_a    <= ReadA_data;
                    op_b    <= ALU_B_Sel ? Imm_Out : read_b;
                    op_q    <= ALU_Op;
                    rd_q    <= Rd_to_RF;
                    wb_en_q <= WB_en;
                    state   <= StExec;
                end
                StExec: begin
                    ALU_Out <= alu_res;
                    NZVC    <= flags;
                    done    <= 1'b1;
                    state   <= StWb;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
